key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder_pkg.sv | 23 ++
 rtl/key_event_decoder_if.sv | 20 ++
 rtl/key_event_decoder_fsm.sv | 118 +++++++++++
 rtl/key_event_decoder.sv | 110 +++++++++++
 tb/tb_key_event_decoder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/key_event_decoder_pkg.sv
// Shared types for the key event decoder: event codes and per-key FSM states.
package key_evt_pkg;

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_LONG   = 2'd1;
    localparam logic [1:0] EVT_DOUBLE = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } key_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Serialized key event port: valid/ready handshake plus key index, code and drop pulse.
interface key_event_decoder_if #(
    parameter int KEY_W = 2
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic [1:0]       evt_code;
    logic             evt_drop;

    modport master (
        output evt_valid, evt_key, evt_code, evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_key, evt_code, evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/key_event_decoder_fsm.sv
// Per-key press classifier. Auto-repeat in HOLD is enabled by defining KEY_EVT_REPEAT_EN.
//
// state  | meaning
// IDLE   | key released, nothing pending
// PRESS1 | first press in progress, timing toward LONG
// WAIT2  | released after first press, double-click window open
// PRESS2 | second press in progress
// HOLD   | long press already reported, waiting for release (repeats if enabled)
module key_event_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_TICKS   = 50,
    parameter int DCLICK_TICKS = 15,
    parameter int REPEAT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lv,
    input  logic       tick,
    output logic       emit,
    output logic [1:0] code
);

    localparam int CNT_MAX = max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS);
    localparam int CW      = $clog2(CNT_MAX + 1);

    key_state_t    state;
    logic [CW-1:0] cnt;

    // Release is tested before tick in every state so it wins a same-cycle tie.
    always_ff @(posedge clk) begin
        emit <= 1'b0;
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= EVT_SHORT;
        end else begin
            case (state)
                IDLE: begin
                    if (lv) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (!lv) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == CW'(LONG_TICKS - 1)) begin
                            emit  <= 1'b1;
                            code  <= EVT_LONG;
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WAIT2: begin
                    if (lv) begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == CW'(DCLICK_TICKS - 1)) begin
                            emit  <= 1'b1;
                            code  <= EVT_SHORT;
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRESS2: begin
                    if (!lv) begin
                        emit  <= 1'b1;
                        code  <= EVT_DOUBLE;
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        // Held second press still reports DOUBLE, never LONG.
                        if (cnt == CW'(LONG_TICKS - 1)) begin
                            emit  <= 1'b1;
                            code  <= EVT_DOUBLE;
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!lv) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
`ifdef KEY_EVT_REPEAT_EN
                    else if (tick) begin
                        if (cnt == CW'(REPEAT_TICKS - 1)) begin
                            emit <= 1'b1;
                            code <= EVT_REPEAT;
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Key event decoder top: tick prescaler, input register, per-key FSMs, pending slots and
// fixed-priority output register. Optional auto-repeat via KEY_EVT_REPEAT_EN.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int KEY_NUM      = 3,
    parameter int TICK_CYCLES  = 1_000_000,
    parameter int LONG_TICKS   = 50,
    parameter int DCLICK_TICKS = 15,
    parameter int REPEAT_TICKS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_level,
    key_event_decoder_if.master evt
);

    localparam int KW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PW-1:0]      pcnt;
    logic               tick;
    logic [KEY_NUM-1:0] lv;
    logic [KEY_NUM-1:0] emit;
    logic [1:0]         emit_code [KEY_NUM];
    logic [KEY_NUM-1:0] slot_full;
    logic [1:0]         slot_code [KEY_NUM];
    logic [KEY_NUM-1:0] drain;
    logic [KW-1:0]      sel;
    logic               any_full;
    logic               load;

    assign tick = (pcnt == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            lv   <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            lv   <= key_level;
        end
    end

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
        key_event_fsm #(
            .LONG_TICKS  (LONG_TICKS),
            .DCLICK_TICKS(DCLICK_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_fsm (
            .clk (clk),
            .rst (rst),
            .lv  (lv[g]),
            .tick(tick),
            .emit(emit[g]),
            .code(emit_code[g])
        );
    end

    // Lowest index wins; scanning downward leaves the smallest full index in sel.
    always_comb begin
        sel      = '0;
        any_full = 1'b0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (slot_full[i]) begin
                sel      = KW'(i);
                any_full = 1'b1;
            end
        end
    end

    assign load = !evt.evt_valid || evt.evt_ready;

    always_comb begin
        drain = '0;
        if (load && any_full) drain[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full     <= '0;
            evt.evt_drop  <= 1'b0;
            for (int i = 0; i < KEY_NUM; i++) slot_code[i] <= EVT_SHORT;
        end else begin
            evt.evt_drop <= |(emit & slot_full & ~drain);
            for (int i = 0; i < KEY_NUM; i++) begin
                if (drain[i]) slot_full[i] <= 1'b0;
                if (emit[i] && (!slot_full[i] || drain[i])) begin
                    slot_full[i] <= 1'b1;
                    slot_code[i] <= emit_code[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_key   <= '0;
            evt.evt_code  <= EVT_SHORT;
        end else if (load) begin
            evt.evt_valid <= any_full;
            if (any_full) begin
                evt.evt_key  <= sel;
                evt.evt_code <= slot_code[sel];
            end
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with short tick parameters; honours KEY_EVT_REPEAT_EN.
module tb_key_event_decoder;

    localparam int KEY_NUM = 3;
    localparam int KW      = 2;

    typedef struct packed {
        logic [1:0] key;
        logic [1:0] code;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [KEY_NUM-1:0] key_level;

    exp_t exp_q[$];
    int   acc_cyc[$];
    int   checks    = 0;
    int   failures  = 0;
    int   drop_cnt  = 0;
    int   cycle     = 0;

    key_event_decoder_if #(.KEY_W(KW)) evt_if ();

    key_event_decoder #(
        .KEY_NUM     (KEY_NUM),
        .TICK_CYCLES (4),
        .LONG_TICKS  (5),
        .DCLICK_TICKS(3),
        .REPEAT_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_level(key_level),
        .evt      (evt_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_if.evt_drop) drop_cnt++;
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                acc_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got key=%0d code=%0d expected none",
                             evt_if.evt_key, evt_if.evt_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("evt_key", 32'(evt_if.evt_key), 32'(e.key));
                    check("evt_code", 32'(evt_if.evt_code), 32'(e.code));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int key, input int code);
        exp_t e;
        e.key  = 2'(key);
        e.code = 2'(code);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic click(input logic [KEY_NUM-1:0] keys);
        key_level = keys;
        cyc(4);
        key_level = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        key_level        = '0;
        evt_if.evt_ready = 1'b1;
        cyc(3);
        check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("rst_key", 32'(evt_if.evt_key), 32'd0);
        check("rst_code", 32'(evt_if.evt_code), 32'd0);
        check("rst_drop", 32'(evt_if.evt_drop), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Short click on key0
        push(0, 0);
        key_level = 3'b001;
        cyc(8);
        key_level = 3'b000;
        cyc(6);
        check("short_not_early", 32'(exp_q.size()), 32'd1);
        wait_drain("short_drain", 40);
        cyc(30);

        // Long press on key1, 12 ticks
        push(1, 1);
`ifdef KEY_EVT_REPEAT_EN
        push(1, 3);
        push(1, 3);
        push(1, 3);
`endif
        key_level = 3'b010;
        cyc(14);
        check("long_not_early", 32'(exp_q.size() > 0), 32'd1);
        cyc(34);
        key_level = 3'b000;
        wait_drain("long_drain", 60);
        cyc(30);

        // Double click on key2
        push(2, 2);
        click(3'b100);
        cyc(4);
        click(3'b100);
        wait_drain("double_drain", 40);
        cyc(30);

        // Backpressure and arbitration
        evt_if.evt_ready = 1'b0;
        push(0, 0);
        push(1, 0);
        click(3'b011);
        cyc(30);
        check("bp_valid", 32'(evt_if.evt_valid), 32'd1);
        check("bp_key", 32'(evt_if.evt_key), 32'd0);
        check("bp_code", 32'(evt_if.evt_code), 32'd0);
        cyc(5);
        check("bp_key_stable", 32'(evt_if.evt_key), 32'd0);
        check("bp_valid_stable", 32'(evt_if.evt_valid), 32'd1);
        acc_cyc.delete();
        evt_if.evt_ready = 1'b1;
        wait_drain("bp_drain", 20);
        check("bp_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() == 2)
            check("bp_back_to_back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        cyc(10);

        // Overflow: key1 occupies the output, key0 fills its slot then overflows
        evt_if.evt_ready = 1'b0;
        drop_cnt = 0;
        push(1, 0);
        click(3'b010);
        cyc(25);
        push(0, 0);
        click(3'b001);
        cyc(25);
        check("ovf_no_drop_yet", 32'(drop_cnt), 32'd0);
        click(3'b001);
        cyc(25);
        check("ovf_drop_once", 32'(drop_cnt), 32'd1);
        check("ovf_hold_key", 32'(evt_if.evt_key), 32'd1);
        evt_if.evt_ready = 1'b1;
        wait_drain("ovf_drain", 20);
        cyc(30);
        check("ovf_drop_total", 32'(drop_cnt), 32'd1);

        // Reset while key0 sits in PRESS1 with cnt=4
        key_level = 3'b001;
        cyc(18);
        rst = 1'b1;
        cyc(3);
        check("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("mid_rst_key", 32'(evt_if.evt_key), 32'd0);
        check("mid_rst_code", 32'(evt_if.evt_code), 32'd0);
        check("mid_rst_drop", 32'(evt_if.evt_drop), 32'd0);
        rst = 1'b0;
        push(0, 1);
        cyc(15);
        check("rst_long_not_early", 32'(exp_q.size()), 32'd1);
        cyc(8);
        key_level = 3'b000;
        wait_drain("rst_long_drain", 40);
        cyc(30);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
